// File: rtl/acc_mem_arbiter.sv
// acc_mem_arbiter: round-robin arbiter that lets NUM_ACC accelerator requesters
// share one single-port data memory, answering each with a one-cycle
// read-valid or write-done pulse. CPU memory use (cpu_mem_active) blocks new
// grants but never pre-empts a transaction already under way.
// Optional build macro ACC_ARB_STATS_EN adds saturating grant and CPU-stall
// counters (stat_grants, stat_wait_cycles).
module acc_mem_arbiter #(
   parameter int NUM_ACC   = 4,
   parameter int ADDR_W    = 16,
   parameter int RD_DATA_W = 512,
   parameter int WR_DATA_W = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cpu_mem_active,
   input  logic [NUM_ACC-1:0]             acc_read_en,
   input  logic [NUM_ACC*ADDR_W-1:0]      acc_read_addr,
   input  logic [NUM_ACC-1:0]             acc_write_en,
   input  logic [NUM_ACC*ADDR_W-1:0]      acc_write_addr,
   input  logic [NUM_ACC*WR_DATA_W-1:0]   acc_write_data,
   output logic [RD_DATA_W-1:0]           acc_read_data,
   output logic [NUM_ACC-1:0]             acc_read_data_valid,
   output logic [NUM_ACC-1:0]             acc_write_done,
   output logic                           mem_en,
   output logic                           mem_wr,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [WR_DATA_W-1:0]           mem_wdata,
   input  logic [RD_DATA_W-1:0]           mem_rdata
`ifdef ACC_ARB_STATS_EN
   ,
   output logic [31:0]                    stat_grants,
   output logic [31:0]                    stat_wait_cycles
`endif
);

   localparam int PTR_W = $clog2(NUM_ACC);
   localparam logic [PTR_W:0] NUM_ACC_P = (PTR_W+1)'(NUM_ACC);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RWAIT = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t           state_reg;
   logic [PTR_W-1:0] ptr_reg;
   logic [PTR_W-1:0] grant_reg;

   // Per-requester views of the flattened request buses
   logic [ADDR_W-1:0]    rd_addr_arr [NUM_ACC];
   logic [ADDR_W-1:0]    wr_addr_arr [NUM_ACC];
   logic [WR_DATA_W-1:0] wr_data_arr [NUM_ACC];
   logic [NUM_ACC-1:0]   grant_onehot;

   generate
      for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_unpack
         assign rd_addr_arr[gi]  = acc_read_addr[gi*ADDR_W +: ADDR_W];
         assign wr_addr_arr[gi]  = acc_write_addr[gi*ADDR_W +: ADDR_W];
         assign wr_data_arr[gi]  = acc_write_data[gi*WR_DATA_W +: WR_DATA_W];
         assign grant_onehot[gi] = (grant_reg == PTR_W'(gi));
      end
   endgenerate

   logic [NUM_ACC-1:0] req_any;
   assign req_any = acc_read_en | acc_write_en;

   logic             grant_found;
   logic [PTR_W-1:0] grant_next;
   logic [PTR_W:0]   scan_sum;

   // Round-robin scan: first pending requester at or after ptr, wrapping
   always_comb begin
      grant_found = 1'b0;
      grant_next  = '0;
      scan_sum    = '0;
      for (int k = 0; k < NUM_ACC; k++) begin
         scan_sum = {1'b0, ptr_reg} + (PTR_W+1)'(k);
         if (scan_sum >= NUM_ACC_P)
            scan_sum = scan_sum - NUM_ACC_P;
         if (!grant_found && req_any[scan_sum[PTR_W-1:0]]) begin
            grant_found = 1'b1;
            grant_next  = scan_sum[PTR_W-1:0];
         end
      end
   end

   logic [PTR_W:0]   grant_inc;
   logic [PTR_W-1:0] ptr_next;
   assign grant_inc = {1'b0, grant_reg} + {{PTR_W{1'b0}}, 1'b1};
   assign ptr_next  = (grant_inc >= NUM_ACC_P) ? '0 : grant_inc[PTR_W-1:0];

   // Arbitration FSM; mem_addr/mem_wdata/mem_wr double as the request latch
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg           <= ST_IDLE;
         ptr_reg             <= '0;
         grant_reg           <= '0;
         acc_read_data       <= '0;
         acc_read_data_valid <= '0;
         acc_write_done      <= '0;
         mem_en              <= 1'b0;
         mem_wr              <= 1'b0;
         mem_addr            <= '0;
         mem_wdata           <= '0;
      end else begin
         acc_read_data_valid <= '0;
         acc_write_done      <= '0;
         mem_en              <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (!cpu_mem_active && grant_found) begin
                  // A read beats the same requester's write
                  grant_reg <= grant_next;
                  mem_en    <= 1'b1;
                  mem_wr    <= !acc_read_en[grant_next];
                  mem_addr  <= acc_read_en[grant_next] ? rd_addr_arr[grant_next]
                                                       : wr_addr_arr[grant_next];
                  mem_wdata <= wr_data_arr[grant_next];
                  state_reg <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (mem_wr) begin
                  acc_write_done <= grant_onehot;
                  state_reg      <= ST_RESP;
               end else begin
                  state_reg      <= ST_RWAIT;
               end
            end
            ST_RWAIT: begin
               acc_read_data       <= mem_rdata;
               acc_read_data_valid <= grant_onehot;
               state_reg           <= ST_RESP;
            end
            ST_RESP: begin
               ptr_reg   <= ptr_next;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

`ifdef ACC_ARB_STATS_EN
   // Saturating counters: completed grants and CPU-blocked pending cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_grants      <= '0;
         stat_wait_cycles <= '0;
      end else begin
         if (state_reg == ST_RESP && stat_grants != 32'hFFFF_FFFF)
            stat_grants <= stat_grants + 32'd1;
         if (state_reg == ST_IDLE && cpu_mem_active && (|req_any) &&
             stat_wait_cycles != 32'hFFFF_FFFF)
            stat_wait_cycles <= stat_wait_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// tb_acc_mem_arbiter: directed stimulus for acc_mem_arbiter. A transaction-level
// model (grant decision + fixed latencies) predicts every output per cycle and a
// compare process checks each cycle; directed steps also pin literal values.
// Define ACC_ARB_STATS_EN to also check the statistics counters.
module tb_acc_mem_arbiter;

   localparam int NA   = 4;
   localparam int AW   = 16;
   localparam int RW   = 512;
   localparam int WW   = 32;
   localparam int MAXC = 512;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cpu;
   logic [NA-1:0]   rd_en, wr_en;
   logic [AW-1:0]   ra [NA];
   logic [AW-1:0]   wa [NA];
   logic [WW-1:0]   wd [NA];
   logic [NA*AW-1:0] acc_read_addr, acc_write_addr;
   logic [NA*WW-1:0] acc_write_data;
   logic [RW-1:0]   acc_read_data;
   logic [NA-1:0]   acc_read_data_valid, acc_write_done;
   logic            mem_en, mem_wr;
   logic [AW-1:0]   mem_addr;
   logic [WW-1:0]   mem_wdata;
   logic [RW-1:0]   mem_rdata;
`ifdef ACC_ARB_STATS_EN
   logic [31:0]     stat_grants, stat_wait_cycles;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NA; i++) begin
         acc_read_addr[i*AW +: AW]  = ra[i];
         acc_write_addr[i*AW +: AW] = wa[i];
         acc_write_data[i*WW +: WW] = wd[i];
      end
   end

   acc_mem_arbiter #(.NUM_ACC(NA), .ADDR_W(AW), .RD_DATA_W(RW), .WR_DATA_W(WW)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .cpu_mem_active      (cpu),
      .acc_read_en         (rd_en),
      .acc_read_addr       (acc_read_addr),
      .acc_write_en        (wr_en),
      .acc_write_addr      (acc_write_addr),
      .acc_write_data      (acc_write_data),
      .acc_read_data       (acc_read_data),
      .acc_read_data_valid (acc_read_data_valid),
      .acc_write_done      (acc_write_done),
      .mem_en              (mem_en),
      .mem_wr              (mem_wr),
      .mem_addr            (mem_addr),
      .mem_wdata           (mem_wdata),
      .mem_rdata           (mem_rdata)
`ifdef ACC_ARB_STATS_EN
      ,
      .stat_grants         (stat_grants),
      .stat_wait_cycles    (stat_wait_cycles)
`endif
   );

   // Memory contents: a fixed pattern derived from the address
   function automatic logic [RW-1:0] pat(input logic [AW-1:0] a);
      logic [RW-1:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         r[i*32 +: 32] = {a, a ^ 16'(i * 4369)};
      return r;
   endfunction

   function automatic void chk(input string nm, input logic [RW-1:0] act,
                               input logic [RW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, req);
      end
   endfunction

   // Memory: read data appears exactly one cycle after a read strobe, garbage otherwise
   initial begin
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         if (mem_en === 1'b1 && mem_wr === 1'b0) mem_rdata <= pat(mem_addr);
         else                                   mem_rdata <= {16{32'hBAD0_BAD0}};
      end
   end

   // ---------------- transaction-level model ----------------
   bit            exp_en    [MAXC];
   bit            exp_wr    [MAXC];
   bit [AW-1:0]   exp_addr  [MAXC];
   bit [WW-1:0]   exp_wdata [MAXC];
   bit [NA-1:0]   exp_vld   [MAXC];
   bit [NA-1:0]   exp_done  [MAXC];
   bit            exp_rd_new[MAXC];
   bit [RW-1:0]   exp_rd_val[MAXC];
   bit            exp_ginc  [MAXC];
   bit            exp_rst   [MAXC];
   int            free_c = 0;
   int            m_ptr  = 0;
   int            m_wait = 0;

   initial begin
      int g, p;
      logic [NA-1:0] req;
      bit is_rd;
      forever begin
         @(posedge clk);
         cyc++;
         if (cyc < MAXC - 8) begin
            if (!rst_n) begin
               for (int c = cyc; c < cyc + 5; c++) begin
                  exp_en[c] = 0; exp_vld[c] = '0; exp_done[c] = '0;
                  exp_rd_new[c] = 0; exp_ginc[c] = 0;
               end
               exp_rst[cyc] = 1;
               free_c = cyc;
               m_ptr  = 0;
               m_wait = 0;
            end else if (cyc - 1 >= free_c) begin
               req = rd_en | wr_en;
               if (req != '0) begin
                  if (cpu) begin
                     m_wait++;
                  end else begin
                     g = -1;
                     for (int k = 0; k < NA; k++)
                        if (g < 0 && req[(m_ptr + k) % NA]) g = (m_ptr + k) % NA;
                     is_rd           = rd_en[g];
                     exp_en[cyc]     = 1;
                     exp_wr[cyc]     = !is_rd;
                     exp_addr[cyc]   = is_rd ? ra[g] : wa[g];
                     exp_wdata[cyc]  = wd[g];
                     p = cyc + (is_rd ? 2 : 1);
                     if (is_rd) begin
                        exp_vld[p][g]  = 1'b1;
                        exp_rd_new[p]  = 1;
                        exp_rd_val[p]  = pat(ra[g]);
                     end else begin
                        exp_done[p][g] = 1'b1;
                     end
                     exp_ginc[p+1] = 1;
                     free_c = p + 1;
                     m_ptr  = (g + 1) % NA;
                  end
               end
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model
   logic [RW-1:0] m_rdata = '0;
   int            m_grants = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (cyc >= 1 && cyc < MAXC - 8) begin
            if (exp_rst[cyc])    begin m_rdata = '0; m_grants = 0; end
            if (exp_rd_new[cyc]) m_rdata = exp_rd_val[cyc];
            if (exp_ginc[cyc])   m_grants++;
            chk("mem_en", mem_en, exp_en[cyc]);
            if (exp_en[cyc]) begin
               chk("mem_wr", mem_wr, exp_wr[cyc]);
               chk("mem_addr", mem_addr, exp_addr[cyc]);
               if (exp_wr[cyc]) chk("mem_wdata", mem_wdata, exp_wdata[cyc]);
            end
            chk("read_valid", acc_read_data_valid, exp_vld[cyc]);
            chk("write_done", acc_write_done, exp_done[cyc]);
            chk("read_data", acc_read_data, m_rdata);
`ifdef ACC_ARB_STATS_EN
            chk("stat_grants", stat_grants, 32'(m_grants));
            chk("stat_wait_cycles", stat_wait_cycles, 32'(m_wait));
`endif
         end
      end
   end

   // Hard stop if the run ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // ---------------- directed stimulus ----------------
   int rr_idx [5];
   int rr_cyc [5];
   int exp_order [5] = '{0, 1, 2, 3, 0};
   int exp_off   [5] = '{2, 5, 8, 11, 14};

   initial begin
      int nrec, base, cnt;
`ifdef ACC_ARB_STATS_EN
      logic [31:0] w0;
`endif
      rst_n = 1'b0; cpu = 1'b0; rd_en = '0; wr_en = '0;
      for (int i = 0; i < NA; i++) begin ra[i] = '0; wa[i] = '0; wd[i] = '0; end
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      $display("txn reset: cycle=%0d outputs idle", cyc);

      // Single read from requester 0
      ra[0] = 16'h1000; rd_en[0] = 1'b1;
      tick();
      chk("rd_issue_en", mem_en, 1'b1);
      chk("rd_issue_wr", mem_wr, 1'b0);
      chk("rd_issue_addr", mem_addr, 16'h1000);
      repeat (2) tick();
      chk("rd_valid", acc_read_data_valid, 4'b0001);
      chk("rd_data_word0", acc_read_data[31:0], 32'h1000_1000);
      rd_en[0] = 1'b0;
      tick();
      chk("rd_valid_clear", acc_read_data_valid, 4'b0000);
      chk("rd_data_hold", acc_read_data, pat(16'h1000));
      $display("txn read: req=0 addr=1000 cycle=%0d", cyc);
      tick();

      // Single write from requester 2
      wa[2] = 16'h5000; wd[2] = 32'h5; wr_en[2] = 1'b1;
      tick();
      chk("wr_issue_en", mem_en, 1'b1);
      chk("wr_issue_wr", mem_wr, 1'b1);
      chk("wr_issue_addr", mem_addr, 16'h5000);
      chk("wr_issue_data", mem_wdata, 32'h5);
      tick();
      chk("wr_done", acc_write_done, 4'b0100);
      chk("wr_no_valid", acc_read_data_valid, 4'b0000);
      wr_en[2] = 1'b0;
      $display("txn write: req=2 addr=5000 data=5 cycle=%0d", cyc);
      repeat (2) tick();

      // Write request dropped right after grant still completes
      wa[1] = 16'h5100; wd[1] = 32'h77; wr_en[1] = 1'b1;
      tick();
      wr_en[1] = 1'b0;
      chk("drop_issue_addr", mem_addr, 16'h5100);
      tick();
      chk("drop_done", acc_write_done, 4'b0010);
      $display("txn write-dropped: req=1 addr=5100 cycle=%0d", cyc);
      repeat (2) tick();

      // Reset, then round-robin over four held writes
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      for (int i = 0; i < NA; i++) begin wa[i] = 16'h0100 * 16'(i + 1); wd[i] = 32'h10 + 32'(i); end
      wr_en = 4'b1111;
      base = cyc; nrec = 0;
      for (int j = 1; j <= 14; j++) begin
         tick();
         if (acc_write_done != '0) begin
            for (int i = 0; i < NA; i++)
               if (acc_write_done[i] && nrec < 5) begin
                  rr_idx[nrec] = i; rr_cyc[nrec] = cyc - base; nrec++;
               end
         end
         if (j == 14) wr_en = '0;
      end
      chk("rr_count", 32'(nrec), 32'd5);
      for (int i = 0; i < 5; i++) begin
         chk("rr_order", 32'(rr_idx[i]), 32'(exp_order[i]));
         chk("rr_spacing", 32'(rr_cyc[i]), 32'(exp_off[i]));
         $display("txn rr-write: req=%0d done_offset=%0d", rr_idx[i], rr_cyc[i]);
      end
      repeat (2) tick();

      // CPU priority: 10 blocked cycles, then the read issues immediately
`ifdef ACC_ARB_STATS_EN
      w0 = stat_wait_cycles;
`endif
      cpu = 1'b1; ra[1] = 16'h7000; rd_en[1] = 1'b1;
      cnt = 0;
      for (int j = 1; j <= 10; j++) begin
         tick();
         if (mem_en) cnt++;
         if (j == 10) cpu = 1'b0;
      end
      chk("cpu_block_issues", 32'(cnt), 32'd0);
      tick();
      chk("cpu_release_en", mem_en, 1'b1);
      chk("cpu_release_addr", mem_addr, 16'h7000);
`ifdef ACC_ARB_STATS_EN
      chk("cpu_wait_count", stat_wait_cycles - w0, 32'd10);
`endif
      repeat (2) tick();
      chk("cpu_rd_valid", acc_read_data_valid, 4'b0010);
      rd_en[1] = 1'b0;
      $display("txn cpu-blocked read: req=1 addr=7000 cycle=%0d", cyc);
      repeat (2) tick();

      // Same requester read and write: read first
      ra[0] = 16'h2000; wa[0] = 16'h3000; wd[0] = 32'hABCD;
      rd_en[0] = 1'b1; wr_en[0] = 1'b1;
      tick();
      chk("rw_first_wr", mem_wr, 1'b0);
      chk("rw_first_addr", mem_addr, 16'h2000);
      repeat (2) tick();
      chk("rw_valid", acc_read_data_valid, 4'b0001);
      rd_en[0] = 1'b0;
      repeat (2) tick();
      chk("rw_second_wr", mem_wr, 1'b1);
      chk("rw_second_addr", mem_addr, 16'h3000);
      tick();
      chk("rw_done", acc_write_done, 4'b0001);
      wr_en[0] = 1'b0;
      $display("txn read+write: req=0 cycle=%0d", cyc);
      repeat (2) tick();

      // Reset during RWAIT aborts the read; pointer restarts at 0
      ra[3] = 16'h4000; ra[0] = 16'h6000; rd_en[3] = 1'b1;
      tick();
      chk("rst_issue_addr", mem_addr, 16'h4000);
      tick();
      rst_n = 1'b0;
      tick();
      chk("rst_valid", acc_read_data_valid, 4'b0000);
      chk("rst_done", acc_write_done, 4'b0000);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_mem_wr", mem_wr, 1'b0);
      chk("rst_mem_addr", mem_addr, 16'h0000);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_read_data", acc_read_data, '0);
      rst_n = 1'b1; rd_en[0] = 1'b1;
      tick();
      chk("rst_next_addr", mem_addr, 16'h6000);
      repeat (2) tick();
      chk("rst_next_valid", acc_read_data_valid, 4'b0001);
      rd_en[0] = 1'b0;
      $display("txn reset-mid-read: regrant req=0 cycle=%0d", cyc);
      repeat (4) tick();
      chk("rst_req3_valid", acc_read_data_valid, 4'b1000);
      rd_en[3] = 1'b0;
      $display("txn read: req=3 addr=4000 cycle=%0d", cyc);
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
